// File: rtl/laser_search_ctrl.sv
// Two-circle coverage search controller: alternately sweeps each circle over a 16x16 grid
// against an external evaluator and keeps the best-covering position per pass.
module laser_search_ctrl #(
  parameter int unsigned MAX_ITER = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic       cand_valid,
  input  logic       cand_ready,
  output logic [3:0] cand_x,
  output logic [3:0] cand_y,
  output logic [3:0] fix_x,
  output logic [3:0] fix_y,
  input  logic       res_valid,
  input  logic [5:0] res_cnt,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic [5:0] best_cnt,
  output logic       busy,
  output logic       DONE
);

  localparam int unsigned PASS_MAX = 2 * MAX_ITER;
  localparam int unsigned PASS_W   = $clog2(PASS_MAX + 1);
  localparam int unsigned CNT_W    = 6;
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(40);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [3:0]        c1x_q, c1y_q, c2x_q, c2y_q, c1x_d, c1y_d, c2x_d, c2y_d;
  logic [3:0]        fix_x_q, fix_y_q, fix_x_d, fix_y_d;
  logic [3:0]        pb_x_q, pb_y_q, pb_x_d, pb_y_d;
  logic [CNT_W-1:0]  best_q, best_d, pb_cnt_q, pb_cnt_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [1:0]        noimp_q, noimp_d;
  logic              mov_q, mov_d;
  logic [7:0]        ras_q, ras_d;
  logic              cand_valid_q, cand_valid_d, busy_q, busy_d, done_q, done_d;
  logic [CNT_W-1:0]  cnt_c;

  assign cnt_c = (res_cnt > CNT_CAP) ? CNT_CAP : res_cnt;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    c1x_d    = c1x_q;
    c1y_d    = c1y_q;
    c2x_d    = c2x_q;
    c2y_d    = c2y_q;
    fix_x_d  = fix_x_q;
    fix_y_d  = fix_y_q;
    pb_x_d   = pb_x_q;
    pb_y_d   = pb_y_q;
    best_d   = best_q;
    pb_cnt_d = pb_cnt_q;
    pass_d   = pass_q;
    noimp_d  = noimp_q;
    mov_d    = mov_q;
    ras_d    = ras_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        c1x_d    = 4'd0;
        c1y_d    = 4'd0;
        c2x_d    = 4'd15;
        c2y_d    = 4'd15;
        fix_x_d  = 4'd15;
        fix_y_d  = 4'd15;
        pb_x_d   = 4'd0;
        pb_y_d   = 4'd0;
        best_d   = '0;
        pb_cnt_d = '0;
        pass_d   = '0;
        noimp_d  = 2'd0;
        mov_d    = 1'b0;
        ras_d    = 8'd0;
        state_d  = S_ISSUE;
      end
      S_ISSUE: begin
        if (cand_valid_q && cand_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) begin
          if (cnt_c > pb_cnt_q) begin
            pb_cnt_d = cnt_c;
            pb_x_d   = ras_q[3:0];
            pb_y_d   = ras_q[7:4];
          end
          if (ras_q == 8'hFF) begin
            state_d = S_COMMIT;
          end else begin
            ras_d   = ras_q + 8'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_COMMIT: begin
        if (!mov_q) begin
          c1x_d = pb_x_q;
          c1y_d = pb_y_q;
        end else begin
          c2x_d = pb_x_q;
          c2y_d = pb_y_q;
        end
        best_d  = pb_cnt_q;
        noimp_d = (pb_cnt_q > best_q) ? 2'd0 : noimp_q + 2'd1;
        pass_d  = pass_q + PASS_W'(1);
        mov_d   = ~mov_q;
        // The circle just committed becomes fixed; the other starts the next pass as pass-best.
        fix_x_d = pb_x_q;
        fix_y_d = pb_y_q;
        pb_x_d  = fix_x_q;
        pb_y_d  = fix_y_q;
        ras_d   = 8'd0;
        if (noimp_d == 2'd2 || pass_d == PASS_W'(PASS_MAX)) state_d = S_FIN;
        else                                              state_d = S_ISSUE;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cand_valid_d = (state_d == S_ISSUE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      c1x_q        <= '0;
      c1y_q        <= '0;
      c2x_q        <= '0;
      c2y_q        <= '0;
      fix_x_q      <= '0;
      fix_y_q      <= '0;
      pb_x_q       <= '0;
      pb_y_q       <= '0;
      best_q       <= '0;
      pb_cnt_q     <= '0;
      pass_q       <= '0;
      noimp_q      <= '0;
      mov_q        <= 1'b0;
      ras_q        <= '0;
      cand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      c1x_q        <= c1x_d;
      c1y_q        <= c1y_d;
      c2x_q        <= c2x_d;
      c2y_q        <= c2y_d;
      fix_x_q      <= fix_x_d;
      fix_y_q      <= fix_y_d;
      pb_x_q       <= pb_x_d;
      pb_y_q       <= pb_y_d;
      best_q       <= best_d;
      pb_cnt_q     <= pb_cnt_d;
      pass_q       <= pass_d;
      noimp_q      <= noimp_d;
      mov_q        <= mov_d;
      ras_q        <= ras_d;
      cand_valid_q <= cand_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cand_valid = cand_valid_q;
  assign cand_x     = ras_q[3:0];
  assign cand_y     = ras_q[7:4];
  assign fix_x      = fix_x_q;
  assign fix_y      = fix_y_q;
  assign C1X        = c1x_q;
  assign C1Y        = c1y_q;
  assign C2X        = c2x_q;
  assign C2Y        = c2y_q;
  assign best_cnt   = best_q;
  assign busy       = busy_q;
  assign DONE       = done_q;

endmodule

// File: doc/laser_search_ctrl.md
LASER_SEARCH_CTRL -- requirements
Module: laser_search_ctrl

Interface
REQ-001 Parameter MAX_ITER, default 8: maximum number of C1+C2 pass pairs per search, so the search is capped at 2*MAX_ITER passes.
REQ-002 CLK  input  1  the single clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a search; sampled only in IDLE.
REQ-005 cand_valid  output  1  a candidate is presented to the coverage evaluator.
REQ-006 cand_ready  input  1  the evaluator accepts the candidate; a transfer occurs when cand_valid && cand_ready.
REQ-007 cand_x, cand_y  output  4 each  coordinates of the moving circle's candidate centre.
REQ-008 fix_x, fix_y  output  4 each  coordinates of the fixed (other) circle's centre.
REQ-009 res_valid  input  1  the evaluator result is valid this cycle.
REQ-010 res_cnt  input  6  number of points (0..40) covered by the union of both circles.
REQ-011 C1X, C1Y, C2X, C2Y  output  4 each  committed circle centres, registered.
REQ-012 best_cnt  output  6  committed union coverage, registered.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 DONE  output  1  one-cycle pulse when a search completes.

Function
REQ-015 States: IDLE, INIT, ISSUE, WAIT, COMMIT, FIN; encoded in 3 bits.
REQ-016 IDLE -> INIT when start=1; start is ignored in all other states.
REQ-017 INIT (1 cycle) loads C1=(0,0), C2=(15,15), best_cnt=0, pass=0, noimp=0, moving circle=C1; then goes to ISSUE.
REQ-018 Each pass scans all 256 candidates in raster order: y outer 0..15, x inner 0..15.
REQ-019 During a C1 pass, fix_x/fix_y = C2; during a C2 pass, fix_x/fix_y = C1.
REQ-020 ISSUE drives cand_valid=1; cand_x, cand_y, fix_x and fix_y are held stable while cand_valid && !cand_ready.
REQ-021 ISSUE -> WAIT on transfer; cand_valid deasserts in WAIT, so at most one candidate is outstanding.
REQ-022 WAIT: on res_valid, compare res_cnt against the pass-best.
REQ-023 The pass-best starts each pass at best_cnt with the moving circle's current position.
REQ-024 The pass-best is replaced only when res_cnt > pass-best (strictly greater); ties keep the earliest candidate in raster order.
REQ-025 WAIT -> ISSUE with the next candidate, or -> COMMIT after candidate (15,15) has resolved.
REQ-026 res_valid outside WAIT is ignored.
REQ-027 COMMIT writes the pass-best position into the moving circle's C registers and the pass-best count into best_cnt.
REQ-028 In COMMIT, noimp clears if the count improved, else noimp increments; pass increments; the moving circle toggles.
REQ-029 COMMIT -> FIN if noimp reaches 2 or pass reaches 2*MAX_ITER; otherwise COMMIT -> ISSUE.
REQ-030 FIN pulses DONE=1 for exactly one cycle, then goes to IDLE; C1X..C2Y and best_cnt hold until the next INIT.
REQ-031 The raster counter is 8 bits and wraps to 0 at every pass start.
REQ-032 Coordinate arithmetic is unsigned 4-bit; no value leaves 0..15.
REQ-033 If res_cnt > 40, the controller treats it as 40.

Reset
REQ-034 RST=1 at a clock edge forces IDLE and clears all internal state.
REQ-035 That same edge sets cand_valid=0, busy=0, DONE=0, C1X=C1Y=C2X=C2Y=0 and best_cnt=0.
REQ-036 RST has priority over start, res_valid and any in-flight transfer; a search interrupted by reset is abandoned, not resumed.

Verification
REQ-037 Evaluator model always returns 0 -> exactly 512 transfers (2 passes) occur; then DONE pulses with C1=(0,0), C2=(15,15), best_cnt=0.
REQ-038 Model returns 7 only for pass-0 candidate (3,9), 0 otherwise -> C1=(3,9), C2=(15,15), best_cnt=7; DONE after 3 passes (768 transfers).
REQ-039 Pass-0 model returns 5 at (2,2) and at (10,10), 0 otherwise -> C1=(2,2) (tie keeps the earlier candidate), best_cnt=5.
REQ-040 Model returns pass+1 for every candidate -> the search stops at 2*MAX_ITER=16 passes with best_cnt=16; DONE pulses once.
REQ-041 Hold cand_ready=0 for 3 cycles with a candidate pending -> cand_valid, cand_x, cand_y, fix_x and fix_y are unchanged on each of those cycles; exactly one transfer follows.
REQ-042 Assert RST during WAIT of pass 1, then start -> all outputs read 0 after reset; the new search repeats the REQ-037 results exactly.
